// File: rtl/fizzbuzz_line_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fizzbuzz_line_gen_pkg
// Description : Shared state encodings, ASCII constants, word tables and
//               helpers for the FizzBuzz line generator.
// Revision    : 1.0 - initial release
// ============================================================================
package fizzbuzz_line_gen_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CLASSIFY = 2'd1;
  localparam logic [1:0] ST_EMIT     = 2'd2;
  localparam logic [1:0] ST_ADVANCE  = 2'd3;

  // ASCII constants
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  // Word tables, first character in the most significant byte
  localparam logic [31:0] FIZZ_STR = 32'h46_69_7A_7A;  // "Fizz"
  localparam logic [31:0] BUZZ_STR = 32'h42_75_7A_7A;  // "Buzz"

  // Classification result registered by the parent in CLASSIFY
  typedef struct packed {
    logic       fizz;
    logic       buzz;
    logic [1:0] ndigits;  // 1..3 significant decimal digits
  } class_t;

  // Pick byte idx (0 = leftmost) out of a 4-character word
  function automatic logic [7:0] str_byte(input logic [31:0] s, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = s[31:24];
      2'd1:    b = s[23:16];
      2'd2:    b = s[15:8];
      default: b = s[7:0];
    endcase
    return b;
  endfunction

  // Digit to ASCII; out-of-range digits still map to 0x30+d
  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fizzbuzz_line_gen_classify.sv
`default_nettype none
// ============================================================================
// Module      : fizzbuzz_line_gen_classify
// Description : Combinational classifier: digit-sum divisibility by 3, units
//               digit buzz test and significant digit count.
// Revision    : 1.0 - initial release
// ============================================================================
module fizzbuzz_line_gen_classify
  import fizzbuzz_line_gen_pkg::*;
(
  input  logic [3:0] digit2_i,
  input  logic [3:0] digit1_i,
  input  logic [3:0] digit0_i,
  output class_t     class_o
);

  // Sum is 6 bits so out-of-range digits (up to 15 each) cannot wrap
  logic [5:0] w_sum;

  // Classify the three digits
  always_comb begin
    w_sum = {2'b00, digit2_i} + {2'b00, digit1_i} + {2'b00, digit0_i};
    class_o.fizz = ((w_sum % 6'd3) == 6'd0);
    class_o.buzz = (digit0_i == 4'd0) || (digit0_i == 4'd5);
    if (digit2_i != 4'd0) begin
      class_o.ndigits = 2'd3;
    end else if (digit1_i != 4'd0) begin
      class_o.ndigits = 2'd2;
    end else begin
      class_o.ndigits = 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fizzbuzz_line_gen.sv
`default_nettype none
// ============================================================================
// Module      : fizzbuzz_line_gen
// Description : Snapshots the BCD counter on request, classifies the value and
//               streams one fixed-width ASCII line, then pulses the counter's
//               increment. Stops (sticky done) after MAX_VALUE.
// Revision    : 1.0 - initial release
// ============================================================================
module fizzbuzz_line_gen
  import fizzbuzz_line_gen_pkg::*;
#(
  parameter int LINE_WIDTH = 8,
  parameter int MAX_VALUE  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line_req,
  input  logic [3:0] digit2,
  input  logic [3:0] digit1,
  input  logic [3:0] digit0,
  output logic       increment,
  output logic [7:0] char_data,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       char_last,
  output logic       busy,
  output logic       done
);

  localparam int             IDX_W    = $clog2(LINE_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WIDTH - 1);
  localparam logic [3:0]     MAX_D2   = 4'(MAX_VALUE / 100);
  localparam logic [3:0]     MAX_D1   = 4'((MAX_VALUE / 10) % 10);
  localparam logic [3:0]     MAX_D0   = 4'(MAX_VALUE % 10);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic [3:0]       d2_q, d1_q, d0_q;
  class_t           cls_q;
  class_t           w_cls;
  logic             w_beat;
  logic             w_is_max;
  logic [4:0]       w_pos;
  logic [7:0]       w_char;

  fizzbuzz_line_gen_classify u_classify (
    .digit2_i (digit2),
    .digit1_i (digit1),
    .digit0_i (digit0),
    .class_o  (w_cls)
  );

  assign w_beat   = (state_q == ST_EMIT) && char_ready;
  assign w_is_max = (d2_q == MAX_D2) && (d1_q == MAX_D1) && (d0_q == MAX_D0);
  assign w_pos    = 5'(idx_q);

  // Next-state logic: FSM, character index and sticky done
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = done_q;
    case (state_q)
      ST_IDLE: begin
        if (line_req && !done_q) begin
          state_d = ST_CLASSIFY;
        end
      end
      ST_CLASSIFY: begin
        idx_d   = '0;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (w_beat) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (w_is_max) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_ADVANCE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, index and done registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Digit snapshot and classification captured during CLASSIFY
  always_ff @(posedge clk) begin
    if (rst) begin
      d2_q  <= 4'd0;
      d1_q  <= 4'd0;
      d0_q  <= 4'd0;
      cls_q <= '0;
    end else if (state_q == ST_CLASSIFY) begin
      d2_q  <= digit2;
      d1_q  <= digit1;
      d0_q  <= digit0;
      cls_q <= w_cls;
    end
  end

  // Character mux: word text or left-aligned digits, space padded
  always_comb begin
    w_char = ASCII_SPACE;
    if (cls_q.fizz && cls_q.buzz) begin
      if (w_pos < 5'd4) begin
        w_char = str_byte(FIZZ_STR, w_pos[1:0]);
      end else if (w_pos < 5'd8) begin
        w_char = str_byte(BUZZ_STR, w_pos[1:0]);
      end
    end else if (cls_q.fizz) begin
      if (w_pos < 5'd4) begin
        w_char = str_byte(FIZZ_STR, w_pos[1:0]);
      end
    end else if (cls_q.buzz) begin
      if (w_pos < 5'd4) begin
        w_char = str_byte(BUZZ_STR, w_pos[1:0]);
      end
    end else begin
      case (cls_q.ndigits)
        2'd3: begin
          if (w_pos == 5'd0)      w_char = digit_char(d2_q);
          else if (w_pos == 5'd1) w_char = digit_char(d1_q);
          else if (w_pos == 5'd2) w_char = digit_char(d0_q);
        end
        2'd2: begin
          if (w_pos == 5'd0)      w_char = digit_char(d1_q);
          else if (w_pos == 5'd1) w_char = digit_char(d0_q);
        end
        default: begin
          if (w_pos == 5'd0)      w_char = digit_char(d0_q);
        end
      endcase
    end
  end

  // Outputs decoded from registered state; data idles at space
  always_comb begin
    char_valid = (state_q == ST_EMIT);
    char_data  = (state_q == ST_EMIT) ? w_char : ASCII_SPACE;
    char_last  = (state_q == ST_EMIT) && (idx_q == LAST_IDX);
    increment  = (state_q == ST_ADVANCE);
    busy       = (state_q != ST_IDLE);
    done       = done_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_fizzbuzz_line_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_fizzbuzz_line_gen
// Description : Directed self-checking bench for fizzbuzz_line_gen, with a
//               small BCD counter model driven by increment.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fizzbuzz_line_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line_req = 1'b0;
  logic       char_ready = 1'b0;
  logic       use_live = 1'b0;
  logic [3:0] m2 = 4'd0, m1 = 4'd0, m0 = 4'd0;
  logic [3:0] c2, c1, c0;
  logic [3:0] w_d2, w_d1, w_d0;
  logic       increment, char_valid, char_last, busy, done;
  logic [7:0] char_data;

  int errors = 0;
  int checks = 0;

  // Capture results of one line
  logic [63:0] cap_line;
  int cap_beats, cap_last_bad, cap_stall_bad, cap_inc, cap_inc_dly, cap_lat, cap_timeout;

  always #5 clk = ~clk;

  assign w_d2 = use_live ? c2 : m2;
  assign w_d1 = use_live ? c1 : m1;
  assign w_d0 = use_live ? c0 : m0;

  // Model of the upstream 3-digit BCD counter, starting at 001
  always @(posedge clk) begin
    if (rst) begin
      c2 <= 4'd0; c1 <= 4'd0; c0 <= 4'd1;
    end else if (increment) begin
      if (c0 != 4'd9) c0 <= c0 + 4'd1;
      else begin
        c0 <= 4'd0;
        if (c1 != 4'd9) c1 <= c1 + 4'd1;
        else begin
          c1 <= 4'd0;
          c2 <= (c2 == 4'd9) ? 4'd0 : c2 + 4'd1;
        end
      end
    end
  end

  fizzbuzz_line_gen #(.LINE_WIDTH(8), .MAX_VALUE(100)) dut (
    .clk        (clk),
    .rst        (rst),
    .line_req   (line_req),
    .digit2     (w_d2),
    .digit1     (w_d1),
    .digit0     (w_d0),
    .increment  (increment),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_last  (char_last),
    .busy       (busy),
    .done       (done)
  );

  function automatic logic [63:0] exp_line(input int n);
    logic [63:0] r;
    r = {8{8'h20}};
    if (n % 15 == 0)      r = "FizzBuzz";
    else if (n % 3 == 0)  r = "Fizz    ";
    else if (n % 5 == 0)  r = "Buzz    ";
    else if (n >= 100) begin
      r[63:56] = 8'(48 + n / 100); r[55:48] = 8'(48 + (n / 10) % 10); r[47:40] = 8'(48 + n % 10);
    end else if (n >= 10) begin
      r[63:56] = 8'(48 + n / 10); r[55:48] = 8'(48 + n % 10);
    end else begin
      r[63:56] = 8'(48 + n);
    end
    return r;
  endfunction

  // Request one line with the given digits and record what comes out
  task automatic collect(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u, input bit stall);
    int k, cyc, last_cyc;
    logic pv, pr, pl;
    logic [7:0] pd;
    cap_line = {8{8'h20}};
    cap_beats = 0; cap_last_bad = 0; cap_stall_bad = 0; cap_inc = 0;
    cap_inc_dly = -1; cap_lat = -1; cap_timeout = 0;
    m2 = h; m1 = t; m0 = u;
    line_req = 1'b1;
    char_ready = 1'b0;
    k = 0; cyc = 0; last_cyc = -1; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 8'h00;
    while (cyc < 200) begin
      @(posedge clk); #1;
      line_req = 1'b0;
      cyc++;
      if (increment) begin
        cap_inc++;
        if (last_cyc >= 0) cap_inc_dly = cyc - last_cyc;
      end
      if (char_valid && cap_lat < 0) cap_lat = cyc;
      if (pv && !pr) begin
        if (!char_valid || char_data !== pd || char_last !== pl) cap_stall_bad++;
      end
      if (char_valid) begin
        char_ready = stall ? (k % 3 == 0) : 1'b1;
        k++;
        if (char_ready) begin
          if (cap_beats < 8) cap_line[63 - 8 * cap_beats -: 8] = char_data;
          if (char_last !== (cap_beats == 7)) cap_last_bad++;
          if (char_last === 1'b1) last_cyc = cyc;
          cap_beats++;
        end
      end else begin
        char_ready = 1'b0;
      end
      pv = char_valid; pr = char_ready; pd = char_data; pl = char_last;
      if (last_cyc >= 0 && cyc >= last_cyc + 3) break;
    end
    if (last_cyc < 0) cap_timeout = 1;
    char_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", char_valid); end
    checks++; if (char_data !== 8'h20) begin errors++; $display("FAIL rst_data: got %h want 20", char_data); end
    checks++; if (char_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b want 0", char_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (increment !== 1'b0) begin errors++; $display("FAIL rst_inc: got %b want 0", increment); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_first_line;
    collect(4'd0, 4'd0, 4'd1, 1'b0);
    checks++; if (cap_timeout != 0) begin errors++; $display("FAIL first_timeout: no last beat seen"); end
    checks++; if (cap_line !== 64'h3120202020202020) begin errors++; $display("FAIL first_line: got %h want 3120202020202020", cap_line); end
    checks++; if (cap_beats != 8) begin errors++; $display("FAIL first_beats: got %0d want 8", cap_beats); end
    checks++; if (cap_last_bad != 0) begin errors++; $display("FAIL first_last: %0d misplaced char_last", cap_last_bad); end
    checks++; if (cap_lat != 2) begin errors++; $display("FAIL first_latency: got %0d want 2", cap_lat); end
    checks++; if (cap_inc != 1) begin errors++; $display("FAIL first_inc_count: got %0d want 1", cap_inc); end
    checks++; if (cap_inc_dly != 1) begin errors++; $display("FAIL first_inc_delay: got %0d want 1", cap_inc_dly); end
  endtask

  task automatic test_patterns;
    logic [11:0] vec [7];
    logic [63:0] exp [7];
    vec[0] = 12'h015; exp[0] = "FizzBuzz";
    vec[1] = 12'h009; exp[1] = "Fizz    ";
    vec[2] = 12'h010; exp[2] = "Buzz    ";
    vec[3] = 12'h097; exp[3] = "97      ";
    vec[4] = 12'h105; exp[4] = "FizzBuzz";
    vec[5] = 12'h000; exp[5] = "FizzBuzz";
    vec[6] = 12'h00B; exp[6] = 64'h3B20202020202020;
    for (int i = 0; i < 7; i++) begin
      collect(vec[i][11:8], vec[i][7:4], vec[i][3:0], 1'b0);
      checks++; if (cap_line !== exp[i]) begin errors++; $display("FAIL pattern_%03h line: got %h want %h", vec[i], cap_line, exp[i]); end
      checks++; if (cap_beats != 8 || cap_timeout != 0) begin errors++; $display("FAIL pattern_%03h beats: got %0d want 8", vec[i], cap_beats); end
      checks++; if (cap_inc != 1) begin errors++; $display("FAIL pattern_%03h inc: got %0d want 1", vec[i], cap_inc); end
    end
  endtask

  task automatic test_stall;
    collect(4'd0, 4'd4, 4'd2, 1'b1);
    checks++; if (cap_line !== "Fizz    ") begin errors++; $display("FAIL stall_line: got %h want %h", cap_line, 64'h46697A7A20202020); end
    checks++; if (cap_beats != 8 || cap_timeout != 0) begin errors++; $display("FAIL stall_beats: got %0d want 8", cap_beats); end
    checks++; if (cap_stall_bad != 0) begin errors++; $display("FAIL stall_hold: %0d changes during stall, want 0", cap_stall_bad); end
    checks++; if (cap_last_bad != 0) begin errors++; $display("FAIL stall_last: %0d misplaced char_last", cap_last_bad); end
    checks++; if (cap_inc != 1) begin errors++; $display("FAIL stall_inc: got %0d want 1", cap_inc); end
  endtask

  task automatic test_reset_mid;
    int incs;
    bit seen;
    m2 = 4'd0; m1 = 4'd9; m0 = 4'd7;
    line_req = 1'b1;
    @(posedge clk); #1;
    line_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (char_valid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL midrst_start: char_valid got 0 want 1"); end
    char_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    char_ready = 1'b0;
    checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", char_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
    incs = 0;
    for (int i = 0; i < 6; i++) begin
      if (increment) incs++;
      @(posedge clk); #1;
    end
    checks++; if (incs != 0) begin errors++; $display("FAIL midrst_inc: got %0d want 0", incs); end
  endtask

  task automatic test_max;
    int vseen, bseen;
    collect(4'd1, 4'd0, 4'd0, 1'b0);
    checks++; if (cap_line !== "Buzz    ") begin errors++; $display("FAIL max_line: got %h want %h", cap_line, 64'h42757A7A20202020); end
    checks++; if (cap_inc != 0) begin errors++; $display("FAIL max_inc: got %0d want 0", cap_inc); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL max_done: got %b want 1", done); end
    vseen = 0; bseen = 0;
    for (int i = 0; i < 14; i++) begin
      line_req = (i == 0 || i == 5);
      char_ready = 1'b1;
      @(posedge clk); #1;
      if (char_valid) vseen++;
      if (busy) bseen++;
    end
    line_req = 1'b0; char_ready = 1'b0;
    checks++; if (vseen != 0) begin errors++; $display("FAIL max_after_valid: got %0d cycles want 0", vseen); end
    checks++; if (bseen != 0) begin errors++; $display("FAIL max_after_busy: got %0d cycles want 0", bseen); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL max_sticky: got %b want 1", done); end
  endtask

  task automatic test_live_count;
    logic [63:0] line;
    int pos, n, incs;
    rst = 1'b1;
    use_live = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    line = {8{8'h20}}; pos = 0; n = 0; incs = 0;
    char_ready = 1'b1;
    line_req = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (increment) incs++;
      if (char_valid && char_ready) begin
        if (pos < 8) line[63 - 8 * pos -: 8] = char_data;
        pos++;
        if (char_last) begin
          n++;
          checks++; if (line !== exp_line(n) || pos != 8) begin errors++; $display("FAIL live_line_%0d: got %h want %h", n, line, exp_line(n)); end
          checks++; if (incs != n - 1) begin errors++; $display("FAIL live_inc_%0d: got %0d want %0d", n, incs, n - 1); end
          pos = 0; line = {8{8'h20}};
        end
      end
      if (done) break;
    end
    line_req = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (increment) incs++;
    end
    char_ready = 1'b0;
    checks++; if (n != 100) begin errors++; $display("FAIL live_lines: got %0d want 100", n); end
    checks++; if (incs != 99) begin errors++; $display("FAIL live_incs: got %0d want 99", incs); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL live_done: got %b want 1", done); end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_patterns();
    test_stall();
    test_reset_mid();
    test_max();
    test_live_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
